// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit ADC: returns the addressed sample on dout.
// Define ADC_RESP_TRISTATE_EN to add a dout_oe port for tri-stating the pin.
//
// state  | meaning
// IDLE   | cs high, dout held 0, waiting for cs fall
// ACTIVE | frame in progress, dout = shift register MSB
module adc_spi_responder #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     sclk,
  input  logic                     din,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  output logic                     dout,
  output logic [2:0]               cur_addr,
  output logic [2:0]               next_addr,
  output logic                     frame_done,
  output logic                     busy
`ifdef ADC_RESP_TRISTATE_EN
  ,
  output logic                     dout_oe
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] shreg;
  logic [3:0]  cnt;
  logic        reload_pend;

  logic cs_s1, cs_s2, cs_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic din_s1, din_s2;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  // Synchronisers carry no reset so a reset taken while cs is low cannot fake a cs fall.
  always_ff @(posedge clk) begin
    cs_s1   <= cs;
    cs_s2   <= cs_s1;
    cs_d    <= cs_s2;
    sclk_s1 <= sclk;
    sclk_s2 <= sclk_s1;
    sclk_d  <= sclk_s2;
    din_s1  <= din;
    din_s2  <= din_s1;
  end

  assign cs_fall   = ~cs_s2 & cs_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;

  function automatic logic [15:0] frame_word(input logic [2:0] ch,
                                             input logic [NUM_CH*DATA_W-1:0] s);
    logic [11:0] lj;
    lj = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 3'(k)) lj[11 -: DATA_W] = s[k*DATA_W +: DATA_W];
    end
    return {4'b0000, lj};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    dout = 1'b0;
    if (state == ACTIVE) begin
      busy = 1'b1;
      dout = shreg[15];
    end
  end

`ifdef ADC_RESP_TRISTATE_EN
  assign dout_oe = busy;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg       <= '0;
      cnt         <= '0;
      reload_pend <= 1'b0;
      cur_addr    <= '0;
      next_addr   <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            cur_addr    <= next_addr;
            shreg       <= frame_word(next_addr, sample_in);
            cnt         <= '0;
            reload_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            cnt         <= '0;
            reload_pend <= 1'b0;
          end else if (sclk_rise) begin
            case (cnt)
              4'd2:    next_addr[2] <= din_s2;
              4'd3:    next_addr[1] <= din_s2;
              4'd4:    next_addr[0] <= din_s2;
              default: ;
            endcase
            if (cnt == 4'd15) begin
              frame_done  <= 1'b1;
              cur_addr    <= next_addr;
              cnt         <= '0;
              reload_pend <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (sclk_fall) begin
            // The leading fall before the first rise of a frame must not consume bit 0.
            if (reload_pend) begin
              shreg       <= frame_word(cur_addr, sample_in);
              reload_pend <= 1'b0;
            end else if (cnt != 4'd0) begin
              shreg <= {shreg[14:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: a reader model drives frames, a monitor checks each frame_done.
module tb_adc_spi_responder;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic sclk = 1'b1;
  logic din = 1'b0;
  logic [NUM_CH*DATA_W-1:0] sample_in = '0;
  logic dout, frame_done, busy;
  logic [2:0] cur_addr, next_addr;
`ifdef ADC_RESP_TRISTATE_EN
  logic dout_oe;
`endif

  adc_spi_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .din(din),
    .sample_in(sample_in), .dout(dout), .cur_addr(cur_addr),
    .next_addr(next_addr), .frame_done(frame_done), .busy(busy)
`ifdef ADC_RESP_TRISTATE_EN
    , .dout_oe(dout_oe)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  addr;
  } frame_t;

  frame_t exp_q[$];
  frame_t cap_q[$];
  frame_t mon_e, mon_c, col_f;
  int total = 0;
  int bad = 0;
  logic [2:0] m_next = 3'd0;
  logic [15:0] col_bits = '0;
  logic [2:0] col_addr = '0;
  int col_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: a frame reads 4 zeros then the channel sample MSB first; out-of-range channels read 0.
  function automatic logic [15:0] ref_word(input logic [2:0] ch);
    logic [15:0] w;
    if (int'(ch) >= NUM_CH) return 16'h0000;
    w = 16'(sample_in[int'(ch)*DATA_W +: DATA_W]);
    return w << (12 - DATA_W);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [2:0] a, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sclk = 1'b0;
      if (i >= 2 && i <= 4) din = a[4-i];
      else din = 1'($urandom_range(0, 1));
      wait_clk(5);
      if (i == 8) check("busy_mid_frame", 32'(busy), 32'd1);
      sclk = 1'b1;
      wait_clk(5);
    end
  endtask

  task automatic issue_frame(input logic [2:0] a, input int chg_at, input logic [11:0] new_val);
    frame_t f;
    logic [2:0] ch;
    ch = m_next;
    f.word = ref_word(ch);
    f.addr = ch;
    exp_q.push_back(f);
    m_next = a;
    clock_bits(a, 0, chg_at);
    if (chg_at < 16 && int'(ch) < NUM_CH) sample_in[int'(ch)*DATA_W +: DATA_W] = new_val;
    clock_bits(a, chg_at, 16 - chg_at);
  endtask

  task automatic single_frame(input logic [2:0] a, input int chg_at, input logic [11:0] new_val);
    cs = 1'b0;
    wait_clk(5);
    issue_frame(a, chg_at, new_val);
    wait_clk(5);
    cs = 1'b1;
    wait_clk(10);
    check("dout_idle", 32'(dout), 32'd0);
    check("next_addr", 32'(next_addr), 32'(m_next));
  endtask

  task automatic abort_frame(input logic [2:0] a, input int n);
    cs = 1'b0;
    wait_clk(5);
    clock_bits(a, 0, n);
    wait_clk(2);
    cs = 1'b1;
    wait_clk(10);
    for (int p = 2; p <= 4 && p < n; p++) m_next[4-p] = a[4-p];
    check("abort_next_addr", 32'(next_addr), 32'(m_next));
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
  endtask

  // Collector: what the reader actually samples on each sclk rise.
  initial forever begin
    @(posedge sclk or posedge cs);
    if (cs) begin
      col_n = 0;
    end else begin
      if (col_n == 0) col_addr = cur_addr;
      col_bits = {col_bits[14:0], dout};
      col_n++;
      if (col_n == 16) begin
        col_f.word = col_bits;
        col_f.addr = col_addr;
        cap_q.push_back(col_f);
        col_n = 0;
      end
    end
  end

  // Monitor: every frame_done high cycle consumes one expected frame.
  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_done_unexpected: got pulse want none");
      end else begin
        mon_e = exp_q.pop_front();
        if (cap_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_capture: got 0 sampled frames want 1");
        end else begin
          mon_c = cap_q.pop_front();
          check("frame_word", 32'(mon_c.word), 32'(mon_e.word));
          check("frame_cur_addr", 32'(mon_c.addr), 32'(mon_e.addr));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    wait_clk(5);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_cur_addr", 32'(cur_addr), 32'd0);
    check("rst_next_addr", 32'(next_addr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef ADC_RESP_TRISTATE_EN
    check("rst_dout_oe", 32'(dout_oe), 32'd0);
`endif
    rst_n = 1'b1;
    wait_clk(3);

    sample_in[0*DATA_W +: DATA_W] = 12'hABC;
    single_frame(3'd0, 16, 12'h0);

    sample_in[5*DATA_W +: DATA_W] = 12'h5A5;
    single_frame(3'd5, 16, 12'h0);
    single_frame(3'd0, 16, 12'h0);

    sample_in[2*DATA_W +: DATA_W] = 12'h123;
    sample_in[7*DATA_W +: DATA_W] = 12'hFFF;
    cs = 1'b0;
    wait_clk(5);
    issue_frame(3'd2, 16, 12'h0);
    issue_frame(3'd7, 16, 12'h0);
    wait_clk(5);
    cs = 1'b1;
    wait_clk(10);
    check("cont_next_addr", 32'(next_addr), 32'd7);
    single_frame(3'd0, 16, 12'h0);

    abort_frame(3'b110, 4);
    single_frame(3'd0, 16, 12'h0);

    sample_in[0*DATA_W +: DATA_W] = 12'h100;
    single_frame(3'd0, 8, 12'h200);

    cs = 1'b0;
    wait_clk(5);
    clock_bits(3'b010, 0, 6);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cur_addr", 32'(cur_addr), 32'd0);
    check("midrst_next_addr", 32'(next_addr), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    m_next = 3'd0;
    cs = 1'b1;
    wait_clk(10);
    single_frame(3'd4, 16, 12'h0);

    for (int it = 0; it < 24; it++) begin
      for (int c = 0; c < NUM_CH; c++) sample_in[c*DATA_W +: DATA_W] = 12'($urandom);
      case ($urandom_range(0, 3))
        0: single_frame(3'($urandom), 16, 12'h0);
        1: begin
          n = $urandom_range(2, 3);
          cs = 1'b0;
          wait_clk(5);
          for (int k = 0; k < n; k++) issue_frame(3'($urandom), 16, 12'h0);
          wait_clk(5);
          cs = 1'b1;
          wait_clk(10);
          check("cont_next_addr", 32'(next_addr), 32'(m_next));
        end
        2: abort_frame(3'($urandom), $urandom_range(1, 15));
        default: single_frame(3'($urandom), $urandom_range(1, 15), 12'($urandom));
      endcase
    end

    wait_clk(20);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("pending_captured", 32'(cap_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Clock-oversampled SPI responder that models the ADC128S022-style 8-channel, 12-bit ADC seen by the line-sensor ADC reader.
- Receives cs/sclk/din from the reader and returns the 12-bit sample of the addressed channel on dout.
- Used for hardware-in-loop and simulation of the PID line follower without the physical ADC; channel values come from a sample_in bus driven by a bench or a sensor emulator.

Parameters:
- NUM_CH, 8, number of channels; the address field is 3 bits, and channels at or above NUM_CH read as 0.
- DATA_W, 12, sample width; the frame length is fixed at 16 bits, so DATA_W must be at most 12.

Ports:
- clk  in  1  system clock; frequency must be at least 8x the sclk frequency.
- rst_n  in  1  synchronous active-low reset.
- cs  in  1  chip select from the reader, active low, asynchronous to clk.
- sclk  in  1  serial clock from the reader, asynchronous to clk; idles high.
- din  in  1  address bits from the reader.
- sample_in  in  NUM_CH*DATA_W  channel values; channel k occupies bits [k*DATA_W +: DATA_W].
- dout  out  1  serial data to the reader.
- cur_addr  out  3  channel being returned in the current frame.
- next_addr  out  3  channel captured from din for the next frame.
- frame_done  out  1  one-clk pulse after the 16th sclk rising edge.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Input synchronisation:
  - cs, sclk and din each pass through a 2-flop synchroniser.
  - Rise and fall of sclk and cs are detected from the synchronised signal and its previous value.
  - Edge-to-action latency is 3 clk: 2 synchroniser stages plus 1 register.
- Reset: dout=0, cur_addr=0, next_addr=0, frame_done=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- IDLE:
  - dout=0, busy=0.
  - On cs falling edge:
    - cur_addr <= next_addr.
    - The 16-bit shift register loads {4'b0000, sample of next_addr, left-justified to 12 bits with zero LSBs}.
    - Counter <= 0; go to ACTIVE.
- ACTIVE:
  - busy=1; dout = shift register MSB.
  - Bit 0 is therefore valid from cs fall onward.
  - On sclk rising edge:
    - If counter is 2, 3 or 4, shift din into next_addr bit [4-counter] (MSB first).
    - Then increment counter.
  - On sclk falling edge: shift the register left by 1, filling with 0, so the next bit appears on dout.
  - When the counter reaches 16 (16th rising edge):
    - Pulse frame_done.
    - cs still low (continuous mode): cur_addr <= next_addr, reload the shift register with the new channel's sample, counter <= 0, stay in ACTIVE.
    - The reload takes effect on the 16th falling edge, so bit 0 of the new frame presents after it.
- cs rising edge, any time:
  - Go to IDLE, dout=0, counter=0, no frame_done pulse.
  - The next_addr bits captured so far are kept; uncaptured bits keep their previous value.
- Address out of range (address >= NUM_CH): returned data is 0, and cur_addr still shows the address.
- sample_in is snapshotted at shift-register load only; changes mid-frame do not affect the frame in flight.
- Simultaneous cs rise and sclk edge in the same clk: cs rise wins and the sclk edge is ignored.
- sclk edges while in IDLE are ignored.
- rst_n low mid-frame: all state returns to reset values on the next clk edge, including next_addr=0.

Optional Feature:
- Macro: ADC_RESP_TRISTATE_EN.
- Defined:
  - Adds output port dout_oe (1 bit), which equals busy.
  - dout_oe=0 in IDLE and during reset.
  - The top level uses it to tri-state the pin like the real converter.
- Undefined: no dout_oe port; dout is driven 0 whenever it is not in ACTIVE.

Test Plan:
- Reset then first frame: ch0=12'hABC, din=0, cs low, 16 sclk at clk/10 -> the 16 bits sampled on sclk rise are 0000_1010_1011_1100, cur_addr=0, frame_done pulses once.
- Address capture: frame 1 drives din bits 2-4 = 3'b101 with ch5=12'h5A5 -> next_addr=5 after frame 1; frame 2 returns 12'h5A5 with cur_addr=5.
- Continuous mode: cs held low for 32 sclk, ch2=12'h123, ch7=12'hFFF; frame 1 addresses 2 and frame 2 addresses 7 -> two frame_done pulses; frame 2 returns 12'h123; frame 3 (next cs) returns 12'hFFF.
- Abort: cs rises after 4 sclk rising edges with din bits 2,3 = 1,1 and a prior next_addr of 0 -> no frame_done, dout=0, next_addr=3'b110.
- Snapshot: change ch0 from 12'h100 to 12'h200 after the 8th sclk -> the frame still returns 12'h100.
- Mid-frame reset: rst_n low for 1 clk after 6 sclk -> all outputs 0, next_addr=0, and the next frame starts cleanly.
